// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and BRAM byte-port signals of the memory access controller.
// The controller takes the slave view; the surrounding system takes the master view.
interface mem_access_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 16
) ();
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  resp_valid;
   logic                  resp_err;
   logic [31:0]           resp_rdata;
   logic                  bram_we;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic [7:0]            bram_din;
   logic [7:0]            bram_dout;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bram_dout,
      input  req_ready, resp_valid, resp_err, resp_rdata, bram_we, bram_addr, bram_din
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bram_dout,
      output req_ready, resp_valid, resp_err, resp_rdata, bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Splits byte/half/word load-store requests into sequential 8-bit BRAM accesses
// and returns one little-endian, optionally sign-extended 32-bit response.
module mem_access_ctrl #(
   parameter int unsigned ADDR_WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   mem_access_ctrl_if.slave bus
);
   localparam int unsigned DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_LAST,
      S_RESP
   } state_t;

   state_t                r_state;
   logic [1:0]            r_idx;
   logic [1:0]            r_last;
   logic [1:0]            r_size;
   logic                  r_uns;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_req_ready;
   logic                  r_resp_valid;
   logic                  r_resp_err;
   logic [DATA_WIDTH-1:0] r_resp_rdata;
   logic                  r_bram_we;
   logic [ADDR_WIDTH-1:0] r_bram_addr;
   logic [7:0]            r_bram_din;

   logic                  w_err;
   logic [1:0]            w_last;
   logic [1:0]            w_idx_next;
   logic [1:0]            w_idx_prev;
   logic [DATA_WIDTH-1:0] w_full;
   logic [DATA_WIDTH-1:0] w_ext;

   // Request decode, and the final byte merged with the captured ones for the response
   always_comb begin
      w_err      = (bus.req_size == 2'd3)
                || ((bus.req_size == 2'd1) && bus.req_addr[0])
                || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'd0));
      w_last     = 2'd3;
      w_idx_next = r_idx + 2'd1;
      w_idx_prev = r_idx - 2'd1;
      w_full     = r_data;
      w_ext      = w_full;
      case (bus.req_size)
         2'd0:    w_last = 2'd0;
         2'd1:    w_last = 2'd1;
         default: w_last = 2'd3;
      endcase
      w_full[{r_last, 3'b000} +: 8] = bus.bram_dout;
      case (r_size)
         2'd0:    w_ext = {{24{~r_uns & w_full[7]}}, w_full[7:0]};
         2'd1:    w_ext = {{16{~r_uns & w_full[15]}}, w_full[15:0]};
         default: w_ext = w_full;
      endcase
   end

   // Sequencer; BRAM outputs are set one edge ahead of the cycle that uses them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= 2'd0;
         r_last       <= 2'd0;
         r_size       <= 2'd0;
         r_uns        <= 1'b0;
         r_wdata      <= '0;
         r_data       <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         r_bram_we    <= 1'b0;
         r_bram_addr  <= '0;
         r_bram_din   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_req_ready <= 1'b0;
                  r_size      <= bus.req_size;
                  r_uns       <= bus.req_unsigned;
                  r_wdata     <= bus.req_wdata;
                  r_last      <= w_last;
                  r_idx       <= 2'd0;
                  if (w_err) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_state      <= S_RESP;
                  end else if (bus.req_we) begin
                     r_bram_we   <= 1'b1;
                     r_bram_addr <= bus.req_addr;
                     r_bram_din  <= bus.req_wdata[7:0];
                     r_state     <= S_WR;
                  end else begin
                     r_bram_addr <= bus.req_addr;
                     r_state     <= S_RD;
                  end
               end
            end
            S_WR: begin
               if (r_idx == r_last) begin
                  r_bram_we    <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_idx       <= w_idx_next;
                  r_bram_addr <= r_bram_addr + ADDR_WIDTH'(1);
                  r_bram_din  <= r_wdata[{w_idx_next, 3'b000} +: 8];
               end
            end
            S_RD: begin
               // bram_dout now carries the byte addressed in the previous cycle
               if (r_idx != 2'd0) begin
                  r_data[{w_idx_prev, 3'b000} +: 8] <= bus.bram_dout;
               end
               if (r_idx == r_last) begin
                  r_state <= S_RD_LAST;
               end else begin
                  r_idx       <= w_idx_next;
                  r_bram_addr <= r_bram_addr + ADDR_WIDTH'(1);
               end
            end
            S_RD_LAST: begin
               r_resp_rdata <= w_ext;
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.bram_we    = r_bram_we;
   assign bus.bram_addr  = r_bram_addr;
   assign bus.bram_din   = r_bram_din;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Byte-sequencing memory access controller between the CPU load/store path and the single-port synchronous 8-bit BRAM. It accepts one byte, halfword or word request at a time over a valid/ready handshake. It breaks the request into consecutive byte accesses on the BRAM port, accounting for the BRAM's one-cycle read latency. It then returns a single assembled, little-endian, optionally sign-extended 32-bit response.

## Interface
- ADDR_WIDTH, 16, byte-address width; matches the BRAM address width.
- clk  in  1  rising-edge clock; shared with the BRAM.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; low bytes are used for byte/half.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  qualifies resp_valid: misaligned or illegal size.
- resp_rdata  out  32  load result; valid with resp_valid on loads.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_din  out  8  BRAM write byte.
- bram_dout  in  8  BRAM read byte; valid the cycle after its address is presented.

## Operation
- Acceptance happens at a rising edge with req_valid && req_ready. At that edge the controller latches req_addr, req_size, req_we, req_unsigned and req_wdata. Input changes after acceptance are ignored.
- N = number of bytes: 1, 2 or 4 by size. Byte i goes to address base+i, modulo 2^ADDR_WIDTH. Byte i maps to data bits [8i+7:8i] (little-endian).
- Error check happens at acceptance. An error is size==3, halfword with addr[0]!=0, or word with addr[1:0]!=0. Error requests go straight to RESP with resp_err=1. They make no BRAM access and leave resp_rdata unchanged.
- States:
  - IDLE: req_ready=1. On accept, go to WR (store), RD (load) or RESP (error).
  - WR: one byte per cycle; bram_we=1, bram_addr=base+idx, bram_din=byte idx. After idx N-1, go to RESP.
  - RD: one address per cycle; bram_we=0, bram_addr=base+idx. From the second RD cycle on, capture bram_dout as byte idx-1. After idx N-1, go to RD_LAST.
  - RD_LAST: capture the final byte (N-1) and assemble; go to RESP.
  - RESP: resp_valid=1 for exactly one cycle; resp_rdata holds the assembled value on loads. Go to IDLE.
- Assembly: bits above 8N are zero-filled when req_unsigned=1. Otherwise they are filled with bit 8N-1. Word loads ignore req_unsigned.
- Outside WR: bram_we=0, and bram_addr/bram_din hold their last values.
- Stores leave resp_rdata unchanged.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, bram_we=0, bram_addr=0, bram_din=0.
- Cycle numbering: C1 is the cycle after the acceptance edge.
- Load: address issue in C1..CN; capture at the ends of C2..C(N+1); resp_valid in C(N+2). Byte = 3, half = 4, word = 6 cycles after acceptance.
- Store: bram_we in C1..CN; resp_valid in C(N+1).
- Error: resp_valid with resp_err=1 in C1.
- The next request can be accepted at the edge ending the cycle after RESP, i.e. the first IDLE cycle. There is no back-to-back overlap.
- Reset mid-operation: everything returns to reset values immediately; bram_we drops asynchronously. Bytes already written remain in memory. No response is issued for the aborted request.
- req_valid high while req_ready=0 has no effect; the requester must hold the request until it is accepted.

## Test plan
- Reset: assert rst mid-WR of a word store at 0x0010. Required: bram_we=0 immediately, req_ready=1, no resp_valid. Bytes written before reset persist, all later bytes are unchanged.
- Word store then load: store 0xDEADBEEF at 0x0100. Required: bytes 0xEF, 0xBE, 0xAD, 0xDE land at 0x0100..0x0103; the store's resp_valid comes 5 cycles after acceptance. The load returns 0xDEADBEEF with resp_valid 6 cycles after acceptance, resp_err=0.
- Sign extension: byte 0x80 at 0x0200. A signed byte load returns 0xFFFFFF80; an unsigned byte load returns 0x00000080. Halfword 0x8001 at 0x0202: signed load returns 0xFFFF8001; unsigned load returns 0x00008001.
- Misalignment: word load at 0x0102, halfword store at 0x0001, and size 3 at 0x0000. Each gives resp_valid with resp_err=1 in C1, bram_we never asserted, and resp_rdata unchanged.
- Handshake: hold req_valid with changing req_addr during a busy period. Required: only the latched request executes. A second request is accepted exactly in the first IDLE cycle after RESP.
- Top of memory: word store then load at 0xFFFC. Required: addresses 0xFFFC..0xFFFF are used and the data round-trips correctly.
